// File: rtl/data_memory_be.sv
// Byte-enabled RV32I data memory with combinational loads, registered stores
// and a one-word-per-cycle clear sequence that runs after every reset.
module data_memory_be #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned PROTECT_ZERO = 1,
  parameter int unsigned DBG_IDX      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        RangeErrM,
  output logic        BusyM,
  output logic [31:0] DM0
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DBG_A    = ADDR_W'(DBG_IDX);
  localparam bit PZ = (PROTECT_ZERO != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [31:0]         r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_idx;
  logic [1:0]          w_lane;
  logic                w_req;
  logic                w_busy;
  logic                w_mis;
  logic                w_rng;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_rdata;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic                w_commit;
  logic                w_clr_we;

  assign w_idx  = ALUResultM[ADDR_W+1:2];
  assign w_lane = ALUResultM[1:0];
  assign w_req  = MemReadM | MemWriteM;
  assign w_busy = (r_state == CLEAR);
  assign w_rng  = w_req & (|ALUResultM[31:ADDR_W+2]);

  always_comb begin
    w_mis = 1'b0;
    case (funct3M)
      3'b000:  w_mis = 1'b0;
      3'b001:  w_mis = ALUResultM[0];
      3'b010:  w_mis = |w_lane;
      3'b100:  w_mis = MemWriteM;
      3'b101:  w_mis = MemWriteM | ALUResultM[0];
      default: w_mis = 1'b1;
    endcase
    w_mis = w_mis & w_req;
  end

  // Clear sequencer: counter wraps to 0 on the final clear, ready for the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else if (r_state == CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) r_state <= READY;
    end
  end

  assign w_word = r_mem[w_idx];

  always_comb begin
    w_byte = w_word[7:0];
    case (w_lane)
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
    endcase
    w_half = ALUResultM[1] ? w_word[31:16] : w_word[15:0];
    case (funct3M)
      3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_rdata = {24'h0, w_byte};
      3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
      3'b101:  w_rdata = {16'h0, w_half};
      3'b010:  w_rdata = w_word;
      default: w_rdata = '0;
    endcase
    if (!MemReadM || w_mis || w_rng || w_busy) w_rdata = '0;
  end

  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (funct3M)
      3'b000: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      3'b010: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
      default: begin
        w_be    = '0;
        w_wdata = '0;
      end
    endcase
  end

  assign w_commit = MemWriteM & ~w_busy & ~w_mis & ~w_rng & ~(PZ && (w_idx == '0));
  // Clear writes are held off while reset is asserted so the array is untouched.
  assign w_clr_we = w_busy & ~rst;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign ReadDataM = w_rdata;
  assign MisalignM = w_mis;
  assign RangeErrM = w_rng;
  assign BusyM     = w_busy;
  assign DM0       = r_mem[DBG_A];

endmodule

// File: doc/data_memory_be.md
DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words; power of two, minimum 4.
REQ-002 Parameter PROTECT_ZERO, default 1: when 1, stores to word 0 are suppressed.
REQ-003 Parameter DBG_IDX, default 0: word index driven on DM0; must be less than DEPTH.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port MemWriteM, input, 1: store request this cycle.
REQ-007 Port MemReadM, input, 1: load request this cycle.
REQ-008 Port funct3M, input, 3: RV32I access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 Port ALUResultM, input, 32: byte address.
REQ-010 Port WriteDataM, input, 32: store data, taken from the low bits per access size.
REQ-011 Port ReadDataM, output, 32: load result after extension.
REQ-012 Port MisalignM, output, 1: current access is misaligned or uses an illegal funct3.
REQ-013 Port RangeErrM, output, 1: current access is beyond DEPTH words.
REQ-014 Port BusyM, output, 1: memory clear in progress; pipeline must stall.
REQ-015 Port DM0, output, 32: contents of word DBG_IDX, combinational.

Function
REQ-016 Word index = ALUResultM[ADDR_W+1:2], where ADDR_W = log2(DEPTH); byte lane = ALUResultM[1:0].
REQ-017 RangeErrM = (MemReadM|MemWriteM) and ALUResultM[31:ADDR_W+2] is nonzero.
REQ-018 MisalignM = (MemReadM|MemWriteM) and any of:
  - halfword access with ALUResultM[0] = 1;
  - word access with ALUResultM[1:0] != 0;
  - funct3 in {011, 110, 111};
  - store with funct3 in {100, 101}.
REQ-019 Reads are combinational; ReadDataM responds in the same cycle with zero latency.
REQ-020 Load extraction:
  - LB/LBU select the byte at the lane, sign- or zero-extended.
  - LH/LHU select the half at ALUResultM[1], sign- or zero-extended.
  - LW returns the full word.
REQ-021 ReadDataM = 0 when MemReadM = 0, MisalignM = 1, RangeErrM = 1, or BusyM = 1.
REQ-022 Store commit at the rising clk edge requires all of: MemWriteM = 1, BusyM = 0, MisalignM = 0, RangeErrM = 0, and not (PROTECT_ZERO = 1 and word index = 0).
REQ-023 Store byte enables:
  - SB writes one lane with WriteDataM[7:0].
  - SH writes two lanes with WriteDataM[15:0].
  - SW writes all four lanes.
  - Unselected lanes keep their old value.
REQ-024 Simultaneous load and store to the same word: ReadDataM shows the pre-store contents in that cycle; the new data is visible from the next cycle.
REQ-025 Clear FSM, two states: CLEAR and READY; reset forces CLEAR with clear counter = 0.
REQ-026 In CLEAR: one word per cycle, word[counter] <- 0 and counter increments; BusyM = 1.
REQ-027 CLEAR -> READY on the edge that clears word DEPTH-1, so CLEAR lasts exactly DEPTH cycles after reset deasserts; BusyM = 0 in READY.
REQ-028 Requests during CLEAR are ignored: no store, ReadDataM = 0; error flags still evaluate combinationally.
REQ-029 Flags are combinational and must not affect the FSM.

Reset
REQ-030 While rst = 1: FSM = CLEAR, counter = 0, BusyM = 1, ReadDataM = 0; array contents are not modified during assertion.
REQ-031 Reset asserted mid-clear or mid-operation restarts the clear from word 0; a full DEPTH-cycle clear follows every deassertion.
REQ-032 After the clear completes, every word reads 0 and DM0 = 0.

Verification
REQ-033 Reset then idle: BusyM = 1 for exactly DEPTH (256) cycles after deassertion, then 0; LW at 0x10 returns 0x00000000.
REQ-034 SW 0x11223344 @0x8, then SB 0xAB @0x9 and SH 0xBEEF @0xA: LW @0x8 = 0xBEEFAB44; LB @0x9 = 0xFFFFFFAB; LBU @0x9 = 0x000000AB; LHU @0xA = 0x0000BEEF.
REQ-035 SW @0x6 and LH @0x3: MisalignM = 1, no store, ReadDataM = 0; funct3 = 011 also gives MisalignM = 1.
REQ-036 SW @0x400 with DEPTH = 256: RangeErrM = 1 and word 0 is unchanged; SW 0x5 @0x0 with PROTECT_ZERO = 1: DM0 stays 0.
REQ-037 Assert rst at clear cycle 100 after SW data is present: BusyM stays 1 for a further 256 cycles after deassertion; all previously stored words read 0.
REQ-038 Same-cycle SW 0x1 and LW @0x20, where the old value is 0x7: ReadDataM = 0x7 in that cycle and 0x1 in the next.
